rename_register_file: RTL and testbench

- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the decoder's issue stage.
- Holds 32 committed 32-bit values.
- For each register, tracks whether a younger in-flight ROB entry will overwrite it, and which ROB index that is.
- The decoder reads source operands and dependency tags here, and records the new producer of rd on every issue.

---
 rtl/rename_register_file.sv | 123 ++++++++++++
 tb/tb_rename_register_file.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags (busy + producer ROB index).
// Optional same-cycle commit-to-query bypass: define RF_COMMIT_BYPASS_EN.
module rename_register_file #(
    parameter int unsigned ROB_IDX_W = 4,
    parameter int unsigned XLEN      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic [4:0]           rob_set_idx,
    input  logic [XLEN-1:0]      rob_set_reg_val,
    input  logic [ROB_IDX_W-1:0] rob_set_recorder,
    input  logic                 rename_valid,
    input  logic [4:0]           rename_rd,
    input  logic [ROB_IDX_W-1:0] rename_rob_idx,
    input  logic [4:0]           query_rs1,
    output logic [XLEN-1:0]      query_val1,
    output logic                 query_busy1,
    output logic [ROB_IDX_W-1:0] query_dep1,
    input  logic [4:0]           query_rs2,
    output logic [XLEN-1:0]      query_val2,
    output logic                 query_busy2,
    output logic [ROB_IDX_W-1:0] query_dep2
);

    localparam int unsigned NUM_REGS = 32;

    logic [XLEN-1:0]      val_q  [NUM_REGS];
    logic [XLEN-1:0]      val_d  [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [ROB_IDX_W-1:0] dep_q  [NUM_REGS];
    logic [ROB_IDX_W-1:0] dep_d  [NUM_REGS];

    logic byp1_c;
    logic byp2_c;

    // Next state: flush beats commit; rename beats the commit's tag-match release.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        dep_d  = dep_q;
        if (rdy_in) begin
            if (clear) begin
                busy_d = '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    dep_d[i] = '0;
                end
            end else begin
                if (rob_set_idx != 5'd0) begin
                    val_d[rob_set_idx] = rob_set_reg_val;
                    if (busy_q[rob_set_idx] && (dep_q[rob_set_idx] == rob_set_recorder)) begin
                        busy_d[rob_set_idx] = 1'b0;
                        dep_d[rob_set_idx]  = '0;
                    end
                end
                if (rename_valid && (rename_rd != 5'd0)) begin
                    busy_d[rename_rd] = 1'b1;
                    dep_d[rename_rd]  = rename_rob_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                dep_q[i] <= '0;
            end
        end else begin
            val_q  <= val_d;
            busy_q <= busy_d;
            dep_q  <= dep_d;
        end
    end

    // A matching in-flight commit may forward its value to the query in the same cycle.
    always_comb begin
        byp1_c = 1'b0;
        byp2_c = 1'b0;
`ifdef RF_COMMIT_BYPASS_EN
        byp1_c = rdy_in && !clear && (query_rs1 != 5'd0) && (query_rs1 == rob_set_idx)
                 && busy_q[query_rs1] && (dep_q[query_rs1] == rob_set_recorder);
        byp2_c = rdy_in && !clear && (query_rs2 != 5'd0) && (query_rs2 == rob_set_idx)
                 && busy_q[query_rs2] && (dep_q[query_rs2] == rob_set_recorder);
`endif
    end

    // Queries see pre-edge state, so an instruction never depends on its own rd.
    always_comb begin
        query_val1  = '0;
        query_busy1 = 1'b0;
        query_dep1  = '0;
        if (query_rs1 != 5'd0) begin
            if (byp1_c) begin
                query_val1 = rob_set_reg_val;
            end else begin
                query_val1  = val_q[query_rs1];
                query_busy1 = busy_q[query_rs1];
                query_dep1  = dep_q[query_rs1];
            end
        end
    end

    always_comb begin
        query_val2  = '0;
        query_busy2 = 1'b0;
        query_dep2  = '0;
        if (query_rs2 != 5'd0) begin
            if (byp2_c) begin
                query_val2 = rob_set_reg_val;
            end else begin
                query_val2  = val_q[query_rs2];
                query_busy2 = busy_q[query_rs2];
                query_dep2  = dep_q[query_rs2];
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Bench for rename_register_file: directed vector table, commit-bypass and async-reset
// sequences, then random traffic against a register-array reference model.
module tb_rename_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [4:0]  rob_set_idx;
    logic [31:0] rob_set_reg_val;
    logic [3:0]  rob_set_recorder;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_rob_idx;
    logic [4:0]  query_rs1;
    logic [31:0] query_val1;
    logic        query_busy1;
    logic [3:0]  query_dep1;
    logic [4:0]  query_rs2;
    logic [31:0] query_val2;
    logic        query_busy2;
    logic [3:0]  query_dep2;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_dep  [32];

    rename_register_file #(.ROB_IDX_W(4), .XLEN(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
        .rob_set_recorder(rob_set_recorder), .rename_valid(rename_valid),
        .rename_rd(rename_rd), .rename_rob_idx(rename_rob_idx),
        .query_rs1(query_rs1), .query_val1(query_val1), .query_busy1(query_busy1),
        .query_dep1(query_dep1), .query_rs2(query_rs2), .query_val2(query_val2),
        .query_busy2(query_busy2), .query_dep2(query_dep2)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic rdy; logic clr; logic [4:0] si; logic [31:0] sv; logic [3:0] sr;
        logic rv; logic [4:0] rd; logic [3:0] ri;
        logic [4:0] q1; logic [31:0] v1; logic b1; logic [3:0] d1;
        logic [4:0] q2; logic [31:0] v2; logic b2; logic [3:0] d2;
    } vec_t;

    function automatic vec_t mk(logic rdy, logic clr, logic [4:0] si, logic [31:0] sv,
                                logic [3:0] sr, logic rv, logic [4:0] rd, logic [3:0] ri,
                                logic [4:0] q1, logic [31:0] v1, logic b1, logic [3:0] d1,
                                logic [4:0] q2, logic [31:0] v2, logic b2, logic [3:0] d2);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.si = si; v.sv = sv; v.sr = sr;
        v.rv = rv; v.rd = rd; v.ri = ri;
        v.q1 = q1; v.v1 = v1; v.b1 = b1; v.d1 = d1;
        v.q2 = q2; v.v2 = v2; v.b2 = b2; v.d2 = d2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [31:0] v1, input logic b1,
                         input logic [3:0] d1, input logic [31:0] v2, input logic b2,
                         input logic [3:0] d2);
        chk({tag, " val1"},  query_val1, v1);
        chk({tag, " busy1"}, 32'(query_busy1), 32'(b1));
        chk({tag, " dep1"},  32'(query_dep1), 32'(d1));
        chk({tag, " val2"},  query_val2, v2);
        chk({tag, " busy2"}, 32'(query_busy2), 32'(b2));
        chk({tag, " dep2"},  32'(query_dep2), 32'(d2));
    endtask

    task automatic drive(input logic rdy, input logic clr, input logic [4:0] si,
                         input logic [31:0] sv, input logic [3:0] sr, input logic rv,
                         input logic [4:0] rd, input logic [3:0] ri,
                         input logic [4:0] q1, input logic [4:0] q2);
        rdy_in = rdy; clear = clr; rob_set_idx = si; rob_set_reg_val = sv;
        rob_set_recorder = sr; rename_valid = rv; rename_rd = rd; rename_rob_idx = ri;
        query_rs1 = q1; query_rs2 = q2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_dep[i] = '0;
        end
    endtask

    // Reference view of what a query should return right now.
    function automatic void model_query(input logic [4:0] rs, output logic [31:0] v,
                                        output logic b, output logic [3:0] d);
        v = m_val[rs]; b = m_busy[rs]; d = m_dep[rs];
        if (rs == 5'd0) begin
            v = '0; b = 1'b0; d = '0;
        end
`ifdef RF_COMMIT_BYPASS_EN
        else if (rdy_in && !clear && rob_set_idx == rs && b && d == rob_set_recorder) begin
            v = rob_set_reg_val; b = 1'b0; d = '0;
        end
`endif
    endfunction

    // Advance one clock and apply the architectural rules to the model.
    task automatic step();
        @(posedge clk_in);
        if (rdy_in) begin
            if (clear) begin
                for (int i = 0; i < 32; i++) begin
                    m_busy[i] = 1'b0; m_dep[i] = '0;
                end
            end else begin
                if (rob_set_idx != 0) begin
                    m_val[rob_set_idx] = rob_set_reg_val;
                    if (m_busy[rob_set_idx] && m_dep[rob_set_idx] == rob_set_recorder) begin
                        m_busy[rob_set_idx] = 1'b0; m_dep[rob_set_idx] = '0;
                    end
                end
                if (rename_valid && rename_rd != 0) begin
                    m_busy[rename_rd] = 1'b1; m_dep[rename_rd] = rename_rob_idx;
                end
            end
        end
        #1;
    endtask

    vec_t tbl[13];

    initial begin
        logic [31:0] ev1, ev2;
        logic        eb1, eb2;
        logic [3:0]  ed1, ed2;
        logic [4:0]  si;
        logic [3:0]  sr;

        tbl[0]  = mk(1,0, 0,32'h0,0,          1,5,3, 5,32'h0,0,0,   0,32'h0,0,0);
        tbl[1]  = mk(1,0, 0,32'h0,0,          1,5,7, 5,32'h0,1,3,   0,32'h0,0,0);
        tbl[2]  = mk(1,0, 5,32'h11,3,         0,0,0, 5,32'h0,1,7,   8,32'h0,0,0);
        tbl[3]  = mk(1,0, 0,32'h0,0,          1,8,2, 5,32'h11,1,7,  8,32'h0,0,0);
        tbl[4]  = mk(1,0, 5,32'h22,7,         0,0,0, 8,32'h0,1,2,   1,32'h0,0,0);
        tbl[5]  = mk(1,0, 8,32'hAB,2,         1,8,9, 5,32'h22,0,0,  6,32'h0,0,0);
        tbl[6]  = mk(1,0, 0,32'h0,0,          1,1,1, 8,32'hAB,1,9,  5,32'h22,0,0);
        tbl[7]  = mk(1,0, 0,32'h0,0,          1,2,2, 1,32'h0,1,1,   2,32'h0,0,0);
        tbl[8]  = mk(1,1, 1,32'h55,1,         1,3,4, 1,32'h0,1,1,   2,32'h0,1,2);
        tbl[9]  = mk(1,0, 0,32'hFFFFFFFF,0,   1,0,4, 1,32'h0,0,0,   2,32'h0,0,0);
        tbl[10] = mk(1,0, 0,32'h0,0,          1,6,5, 0,32'h0,0,0,   3,32'h0,0,0);
        tbl[11] = mk(0,0, 6,32'h77,5,         1,7,1, 6,32'h0,1,5,   7,32'h0,0,0);
        tbl[12] = mk(1,0, 0,32'h0,0,          0,0,0, 6,32'h0,1,5,   7,32'h0,0,0);

        rst_in = 1'b0;
        drive(1,0, 0,32'h0,0, 0,0,0, 5,0);
        model_reset();
        #12;
        chk_q("reset", 32'h0, 0, 4'h0, 32'h0, 0, 4'h0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rdy, tbl[i].clr, tbl[i].si, tbl[i].sv, tbl[i].sr,
                  tbl[i].rv, tbl[i].rd, tbl[i].ri, tbl[i].q1, tbl[i].q2);
            #1;
            chk_q($sformatf("vec%0d", i), tbl[i].v1, tbl[i].b1, tbl[i].d1,
                  tbl[i].v2, tbl[i].b2, tbl[i].d2);
            step();
        end

        // x6 busy on ROB 5: commit it while querying x6 in the same cycle.
        drive(1,0, 6,32'h77,5, 0,0,0, 6,0);
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk_q("commit_same_cycle", 32'h77, 0, 4'h0, 32'h0, 0, 4'h0);
`else
        chk_q("commit_same_cycle", 32'h0, 1, 4'h5, 32'h0, 0, 4'h0);
`endif
        step();
        drive(1,0, 0,32'h0,0, 0,0,0, 6,5);
        #1;
        chk_q("commit_after", 32'h77, 0, 4'h0, 32'h22, 0, 4'h0);

        // Asynchronous reset mid-cycle must clear values without a clock edge.
        #2;
        rst_in = 1'b0;
        #1;
        chk_q("async_reset", 32'h0, 0, 4'h0, 32'h0, 0, 4'h0);
        model_reset();
        #3;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        for (int n = 0; n < 400; n++) begin
            si = 5'($urandom_range(0, 7));
            sr = ($urandom_range(0, 1) == 0) ? m_dep[si] : 4'($urandom);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                  si, $urandom, sr, 1'($urandom), 5'($urandom_range(0, 7)), 4'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            model_query(query_rs1, ev1, eb1, ed1);
            model_query(query_rs2, ev2, eb2, ed2);
            chk_q($sformatf("rand%0d", n), ev1, eb1, ed1, ev2, eb2, ed2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
